multi_mode_ping_pong_counter: RTL and testbench
===============================================

Name: multi_mode_ping_pong_counter

Overview:
- Parametrised successor of the team's 4-bit ping-pong counter: WIDTH-bit up/down counter bounded by run-time min/max.
- Adds programmable step, selectable count mode (ping-pong, wrap-up, wrap-down, hold), synchronous load and bounce/wrap event pulses.
- Used as the pattern/sequence generator feeding display and timing logic in lab designs.

Parameters:
WIDTH, 4, bit width of out, min, max, step, load_value

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
enable  input  1  count enable; 0 = hold out/direction (load still honoured)
flip  input  1  ping-pong mode only: invert direction for this cycle's step
mode  input  2  0 ping-pong, 1 wrap-up, 2 wrap-down, 3 hold
step  input  WIDTH  increment magnitude; 0 treated as 1
load  input  1  synchronous load of load_value
load_value  input  WIDTH  value loaded into out
max  input  WIDTH  upper bound (inclusive)
min  input  WIDTH  lower bound (inclusive)
direction  output  1  registered; 1 = counting up, 0 = down
out  output  WIDTH  registered count value
bounce  output  1  registered 1-cycle pulse: direction reversed at a bound (ping-pong)
wrap  output  1  registered 1-cycle pulse: wrapped to opposite bound (wrap modes)
range_err  output  1  combinational, 1 when min >= max

Behaviour:
- Reset (async, rst_n=0): out=0, direction=1, bounce=0, wrap=0. Released on rst_n=1, first update at next rising clk.
- bounce and wrap default 0 every cycle unless set below.
- Let s = (step==0) ? 1 : step. All sums/differences are computed in WIDTH+1 bits, so no modular wrap occurs.
- Per-edge priority:
  - (1) load=1: out=load_value, direction unchanged, no pulses.
  - (2) range_err=1, or enable=0, or mode=3: hold out and direction.
  - (3) out<min or out>max: re-entry. Mode 2 gives out=max, direction=0. Otherwise out=min, direction=1. No pulses.
  - (4) Normal step, per mode below.
- Ping-pong (mode 0):
  - d = flip ? ~direction : direction.
  - d=1 and out==max: direction=0, out=max(out-s, min), bounce=1.
  - d=1 otherwise: direction=1, out=min(out+s, max).
  - d=0 and out==min: direction=1, out=min(out+s, max), bounce=1.
  - d=0 otherwise: direction=0, out=max(out-s, min).
  - Flip at a bound that points away from the bound is a normal step with no bounce.
  - With s=1, min=0, max=15 the sequence is 0..15,14..0,1..
- Wrap-up (mode 1):
  - direction=1; flip ignored.
  - out+s > max: out=min, wrap=1.
  - Otherwise out=out+s.
- Wrap-down (mode 2):
  - direction=0; flip ignored.
  - out < min+s (i.e. out-s < min): out=max, wrap=1.
  - Otherwise out=out-s.
- Mode, min, max and step are sampled every edge.
  - A change takes effect on the first edge it is present. The re-entry rule covers bounds shrinking below or above out.
- Reset mid-count clears immediately, independent of clk.

Test Plan:
- WIDTH=4, min=0, max=15, s=1, mode 0: reset then enable. Out 0→15 over 15 cycles, then 14. bounce=1 on the cycle out becomes 14 and when it returns to 1 after 0. direction toggles at the same edges.
- Flip held 1 for one cycle at out=7, direction=1 -> out=6, direction=0, bounce=0. Enable=0 for 4 cycles -> out frozen at 6.
- Ping-pong with min=8, max=11 while out=3 -> next edge out=8, direction=1. Then 9,10,11,10,9,8,9.
- min=15, max=0 -> range_err=1 and out/direction frozen. Restore min=0, max=15 -> counting resumes from the held value.
- Wrap-up, min=2, max=12, step=4, out=2 -> 6,10,2 with wrap=1 on the 2. Repeat in wrap-down from 12 -> 8,4,12 with wrap=1.
- Load=1 with load_value=9 while enable=0 -> out=9 next edge. Assert rst_n=0 between clock edges -> out=0, direction=1 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/multi_mode_ping_pong_counter_if.sv
// Control and status bundle for the multi-mode ping-pong counter.
// The master drives the count controls and bounds; the slave (the counter) returns its state.
interface multi_mode_ping_pong_counter_if #(parameter int WIDTH = 4);
  logic             enable;
  logic             flip;
  logic [1:0]       mode;
  logic [WIDTH-1:0] step;
  logic             load;
  logic [WIDTH-1:0] load_value;
  logic [WIDTH-1:0] max;
  logic [WIDTH-1:0] min;
  logic             direction;
  logic [WIDTH-1:0] out;
  logic             bounce;
  logic             wrap;
  logic             range_err;

  modport master (
    output enable, flip, mode, step, load, load_value, max, min,
    input  direction, out, bounce, wrap, range_err
  );

  modport slave (
    input  enable, flip, mode, step, load, load_value, max, min,
    output direction, out, bounce, wrap, range_err
  );
endinterface

// File: rtl/multi_mode_ping_pong_counter.sv
// WIDTH-bit bounded up/down counter with ping-pong, wrap-up, wrap-down and hold modes,
// programmable step, synchronous load and one-cycle bounce/wrap event pulses.
module multi_mode_ping_pong_counter #(
  parameter int WIDTH = 4
) (
  input logic                           clk,
  input logic                           rst_n,
  multi_mode_ping_pong_counter_if.slave bus
);

  typedef enum logic [1:0] {
    MODE_PING      = 2'd0,
    MODE_WRAP_UP   = 2'd1,
    MODE_WRAP_DOWN = 2'd2,
    MODE_HOLD      = 2'd3
  } mode_t;

  logic [WIDTH-1:0] out_q, out_d;
  logic             dir_q, dir_d;
  logic             bounce_q, bounce_d;
  logic             wrap_q, wrap_d;

  logic [WIDTH-1:0] s_w;
  logic [WIDTH:0]   s, cur, lo, hi, up;
  logic [WIDTH-1:0] up_c, dn_w, dn_c;
  logic             down_ok, up_over, d;
  mode_t            mode;

  assign bus.range_err = (bus.min >= bus.max);
  assign bus.out       = out_q;
  assign bus.direction = dir_q;
  assign bus.bounce    = bounce_q;
  assign bus.wrap      = wrap_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_q    <= '0;
      dir_q    <= 1'b1;
      bounce_q <= 1'b0;
      wrap_q   <= 1'b0;
    end else begin
      out_q    <= out_d;
      dir_q    <= dir_d;
      bounce_q <= bounce_d;
      wrap_q   <= wrap_d;
    end
  end

  // Arithmetic is widened by one bit so bound comparisons never alias through modular wrap.
  always_comb begin
    s_w     = (bus.step == '0) ? WIDTH'(1) : bus.step;
    s       = {1'b0, s_w};
    cur     = {1'b0, out_q};
    lo      = {1'b0, bus.min};
    hi      = {1'b0, bus.max};
    up      = cur + s;
    up_over = (up > hi);
    up_c    = up_over ? bus.max : up[WIDTH-1:0];
    down_ok = (cur >= lo + s);
    dn_w    = out_q - s_w;
    dn_c    = down_ok ? dn_w : bus.min;
    mode    = mode_t'(bus.mode);
    d       = bus.flip ? ~dir_q : dir_q;
  end

  always_comb begin
    out_d    = out_q;
    dir_d    = dir_q;
    bounce_d = 1'b0;
    wrap_d   = 1'b0;
    if (bus.load) begin
      out_d = bus.load_value;
    end else if (bus.range_err || !bus.enable || mode == MODE_HOLD) begin
      out_d = out_q;
    end else if (out_q < bus.min || out_q > bus.max) begin
      // Bounds moved past the count: snap back to the bound the mode starts from.
      if (mode == MODE_WRAP_DOWN) begin
        out_d = bus.max;
        dir_d = 1'b0;
      end else begin
        out_d = bus.min;
        dir_d = 1'b1;
      end
    end else begin
      case (mode)
        MODE_PING: begin
          if (d) begin
            if (out_q == bus.max) begin
              dir_d    = 1'b0;
              out_d    = dn_c;
              bounce_d = 1'b1;
            end else begin
              dir_d = 1'b1;
              out_d = up_c;
            end
          end else begin
            if (out_q == bus.min) begin
              dir_d    = 1'b1;
              out_d    = up_c;
              bounce_d = 1'b1;
            end else begin
              dir_d = 1'b0;
              out_d = dn_c;
            end
          end
        end
        MODE_WRAP_UP: begin
          dir_d = 1'b1;
          if (up_over) begin
            out_d  = bus.min;
            wrap_d = 1'b1;
          end else begin
            out_d = up[WIDTH-1:0];
          end
        end
        MODE_WRAP_DOWN: begin
          dir_d = 1'b0;
          if (!down_ok) begin
            out_d  = bus.max;
            wrap_d = 1'b1;
          end else begin
            out_d = dn_w;
          end
        end
        default: begin
          out_d = out_q;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_multi_mode_ping_pong_counter.sv
// Directed self-checking bench for multi_mode_ping_pong_counter at WIDTH=4.
module tb_multi_mode_ping_pong_counter;

  localparam int WIDTH = 4;

  logic clk;
  logic rst_n;
  int   n_compared;
  int   n_mismatched;

  multi_mode_ping_pong_counter_if #(.WIDTH(WIDTH)) bus_if ();

  multi_mode_ping_pong_counter #(.WIDTH(WIDTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b1;
    bus_if.enable = 1'b0; bus_if.flip = 1'b0; bus_if.mode = 2'd0; bus_if.step = 4'd1;
    bus_if.load = 1'b0; bus_if.load_value = 4'd0; bus_if.min = 4'd0; bus_if.max = 4'd15;
    #2 rst_n = 1'b0;
    #10;
    n_compared++;
    if (bus_if.out !== 4'd0) begin
      n_mismatched++; $display("[TB] FAIL reset_out: got %0d expected 0", bus_if.out);
    end
    n_compared++;
    if (bus_if.direction !== 1'b1) begin
      n_mismatched++; $display("[TB] FAIL reset_dir: got %0b expected 1", bus_if.direction);
    end
    n_compared++;
    if (bus_if.bounce !== 1'b0 || bus_if.wrap !== 1'b0) begin
      n_mismatched++; $display("[TB] FAIL reset_pulses: got bounce=%0b wrap=%0b expected 0/0", bus_if.bounce, bus_if.wrap);
    end
    n_compared++;
    if (bus_if.range_err !== 1'b0) begin
      n_mismatched++; $display("[TB] FAIL reset_range_err: got %0b expected 0", bus_if.range_err);
    end
    #1 rst_n = 1'b1;
  endtask

  task automatic test_pingpong();
    logic [3:0] exp_out;
    logic       exp_dir, exp_bounce;
    bus_if.enable = 1'b1;
    for (int i = 1; i <= 31; i++) begin
      tick();
      exp_out    = (i <= 15) ? 4'(i) : ((i <= 30) ? 4'(30 - i) : 4'd1);
      exp_dir    = (i <= 15) ? 1'b1 : ((i <= 30) ? 1'b0 : 1'b1);
      exp_bounce = (i == 16 || i == 31);
      n_compared++;
      if (bus_if.out !== exp_out || bus_if.direction !== exp_dir || bus_if.bounce !== exp_bounce) begin
        n_mismatched++;
        $display("[TB] FAIL pingpong_step%0d: got out=%0d dir=%0b bounce=%0b expected out=%0d dir=%0b bounce=%0b",
                 i, bus_if.out, bus_if.direction, bus_if.bounce, exp_out, exp_dir, exp_bounce);
      end
    end
    repeat (6) tick();
    n_compared++;
    if (bus_if.out !== 4'd7 || bus_if.direction !== 1'b1) begin
      n_mismatched++; $display("[TB] FAIL pingpong_at7: got out=%0d dir=%0b expected 7/1", bus_if.out, bus_if.direction);
    end
  endtask

  task automatic test_flip_and_hold();
    bus_if.flip = 1'b1;
    tick();
    bus_if.flip = 1'b0;
    n_compared++;
    if (bus_if.out !== 4'd6 || bus_if.direction !== 1'b0 || bus_if.bounce !== 1'b0) begin
      n_mismatched++;
      $display("[TB] FAIL flip: got out=%0d dir=%0b bounce=%0b expected 6/0/0", bus_if.out, bus_if.direction, bus_if.bounce);
    end
    bus_if.enable = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      n_compared++;
      if (bus_if.out !== 4'd6 || bus_if.direction !== 1'b0) begin
        n_mismatched++; $display("[TB] FAIL enable_hold%0d: got out=%0d dir=%0b expected 6/0", i, bus_if.out, bus_if.direction);
      end
    end
  endtask

  task automatic test_reentry();
    logic [3:0] exp_seq [7] = '{4'd9, 4'd10, 4'd11, 4'd10, 4'd9, 4'd8, 4'd9};
    logic       exp_dir [7] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
    logic       exp_bnc [7] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    bus_if.load_value = 4'd3; bus_if.load = 1'b1;
    tick();
    bus_if.load = 1'b0;
    n_compared++;
    if (bus_if.out !== 4'd3 || bus_if.direction !== 1'b0) begin
      n_mismatched++; $display("[TB] FAIL load3: got out=%0d dir=%0b expected 3/0", bus_if.out, bus_if.direction);
    end
    bus_if.min = 4'd8; bus_if.max = 4'd11; bus_if.enable = 1'b1;
    tick();
    n_compared++;
    if (bus_if.out !== 4'd8 || bus_if.direction !== 1'b1 || bus_if.bounce !== 1'b0) begin
      n_mismatched++; $display("[TB] FAIL reentry: got out=%0d dir=%0b bounce=%0b expected 8/1/0", bus_if.out, bus_if.direction, bus_if.bounce);
    end
    for (int i = 0; i < 7; i++) begin
      tick();
      n_compared++;
      if (bus_if.out !== exp_seq[i] || bus_if.direction !== exp_dir[i] || bus_if.bounce !== exp_bnc[i]) begin
        n_mismatched++;
        $display("[TB] FAIL narrow_pp%0d: got out=%0d dir=%0b bounce=%0b expected out=%0d dir=%0b bounce=%0b",
                 i, bus_if.out, bus_if.direction, bus_if.bounce, exp_seq[i], exp_dir[i], exp_bnc[i]);
      end
    end
  endtask

  task automatic test_range_err();
    bus_if.min = 4'd15; bus_if.max = 4'd0;
    #1;
    n_compared++;
    if (bus_if.range_err !== 1'b1) begin
      n_mismatched++; $display("[TB] FAIL range_err_set: got %0b expected 1", bus_if.range_err);
    end
    repeat (3) tick();
    n_compared++;
    if (bus_if.out !== 4'd9 || bus_if.direction !== 1'b1) begin
      n_mismatched++; $display("[TB] FAIL range_err_hold: got out=%0d dir=%0b expected 9/1", bus_if.out, bus_if.direction);
    end
    bus_if.min = 4'd0; bus_if.max = 4'd15;
    #1;
    n_compared++;
    if (bus_if.range_err !== 1'b0) begin
      n_mismatched++; $display("[TB] FAIL range_err_clear: got %0b expected 0", bus_if.range_err);
    end
    tick();
    n_compared++;
    if (bus_if.out !== 4'd10 || bus_if.direction !== 1'b1) begin
      n_mismatched++; $display("[TB] FAIL range_resume: got out=%0d dir=%0b expected 10/1", bus_if.out, bus_if.direction);
    end
  endtask

  task automatic test_wrap_modes();
    logic [3:0] up_seq [4] = '{4'd6, 4'd10, 4'd2, 4'd6};
    logic       up_wrp [4] = '{1'b0, 1'b0, 1'b1, 1'b0};
    logic [3:0] dn_seq [3] = '{4'd8, 4'd4, 4'd12};
    logic       dn_wrp [3] = '{1'b0, 1'b0, 1'b1};
    bus_if.mode = 2'd1; bus_if.min = 4'd2; bus_if.max = 4'd12; bus_if.step = 4'd4;
    bus_if.load_value = 4'd2; bus_if.load = 1'b1;
    tick();
    bus_if.load = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      n_compared++;
      if (bus_if.out !== up_seq[i] || bus_if.wrap !== up_wrp[i] || bus_if.direction !== 1'b1 || bus_if.bounce !== 1'b0) begin
        n_mismatched++;
        $display("[TB] FAIL wrap_up%0d: got out=%0d wrap=%0b dir=%0b expected out=%0d wrap=%0b dir=1",
                 i, bus_if.out, bus_if.wrap, bus_if.direction, up_seq[i], up_wrp[i]);
      end
    end
    bus_if.mode = 2'd2; bus_if.load_value = 4'd12; bus_if.load = 1'b1;
    tick();
    bus_if.load = 1'b0;
    n_compared++;
    if (bus_if.out !== 4'd12 || bus_if.wrap !== 1'b0) begin
      n_mismatched++; $display("[TB] FAIL load12: got out=%0d wrap=%0b expected 12/0", bus_if.out, bus_if.wrap);
    end
    for (int i = 0; i < 3; i++) begin
      tick();
      n_compared++;
      if (bus_if.out !== dn_seq[i] || bus_if.wrap !== dn_wrp[i] || bus_if.direction !== 1'b0) begin
        n_mismatched++;
        $display("[TB] FAIL wrap_down%0d: got out=%0d wrap=%0b dir=%0b expected out=%0d wrap=%0b dir=0",
                 i, bus_if.out, bus_if.wrap, bus_if.direction, dn_seq[i], dn_wrp[i]);
      end
    end
  endtask

  task automatic test_hold_step_zero();
    bus_if.mode = 2'd3;
    tick();
    n_compared++;
    if (bus_if.out !== 4'd12 || bus_if.direction !== 1'b0 || bus_if.wrap !== 1'b0) begin
      n_mismatched++; $display("[TB] FAIL mode_hold: got out=%0d dir=%0b wrap=%0b expected 12/0/0", bus_if.out, bus_if.direction, bus_if.wrap);
    end
    bus_if.mode = 2'd1; bus_if.step = 4'd0; bus_if.min = 4'd0; bus_if.max = 4'd15;
    tick();
    n_compared++;
    if (bus_if.out !== 4'd13 || bus_if.direction !== 1'b1) begin
      n_mismatched++; $display("[TB] FAIL step_zero_up: got out=%0d dir=%0b expected 13/1", bus_if.out, bus_if.direction);
    end
    bus_if.mode = 2'd2; bus_if.max = 4'd5;
    tick();
    n_compared++;
    if (bus_if.out !== 4'd5 || bus_if.direction !== 1'b0 || bus_if.wrap !== 1'b0) begin
      n_mismatched++; $display("[TB] FAIL reentry_down: got out=%0d dir=%0b wrap=%0b expected 5/0/0", bus_if.out, bus_if.direction, bus_if.wrap);
    end
    bus_if.max = 4'd15;
    tick();
    n_compared++;
    if (bus_if.out !== 4'd4 || bus_if.direction !== 1'b0) begin
      n_mismatched++; $display("[TB] FAIL step_zero_down: got out=%0d dir=%0b expected 4/0", bus_if.out, bus_if.direction);
    end
  endtask

  task automatic test_load_async_reset();
    bus_if.enable = 1'b0; bus_if.load_value = 4'd9; bus_if.load = 1'b1;
    tick();
    bus_if.load = 1'b0;
    n_compared++;
    if (bus_if.out !== 4'd9 || bus_if.direction !== 1'b0) begin
      n_mismatched++; $display("[TB] FAIL load_disabled: got out=%0d dir=%0b expected 9/0", bus_if.out, bus_if.direction);
    end
    #2 rst_n = 1'b0;
    #1;
    n_compared++;
    if (bus_if.out !== 4'd0 || bus_if.direction !== 1'b1 || bus_if.bounce !== 1'b0 || bus_if.wrap !== 1'b0) begin
      n_mismatched++;
      $display("[TB] FAIL async_reset: got out=%0d dir=%0b bounce=%0b wrap=%0b expected 0/1/0/0",
               bus_if.out, bus_if.direction, bus_if.bounce, bus_if.wrap);
    end
    #3 rst_n = 1'b1;
  endtask

  initial begin
    n_compared   = 0;
    n_mismatched = 0;
    test_reset();
    test_pingpong();
    test_flip_and_hold();
    test_reentry();
    test_range_err();
    test_wrap_modes();
    test_hold_step_zero();
    test_load_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
